// File: rtl/bemicro_cv_nios_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 multiply cell between two requesters.
// Tracks each issue through the cell with a valid/tag pipeline and holds per-requester results.
module bemicro_cv_nios_mul_arbiter #(
  parameter int unsigned Latency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        r0_req_i,
  input  logic [31:0] r0_src1_i,
  input  logic [31:0] r0_src2_i,
  output logic        r0_gnt_o,
  output logic        r0_rsp_valid_o,
  output logic [31:0] r0_result_o,
  input  logic        r0_rsp_ready_i,
  input  logic        r1_req_i,
  input  logic [31:0] r1_src1_i,
  input  logic [31:0] r1_src2_i,
  output logic        r1_gnt_o,
  output logic        r1_rsp_valid_o,
  output logic [31:0] r1_result_o,
  input  logic        r1_rsp_ready_i,
  output logic [31:0] mul_src1_o,
  output logic [31:0] mul_src2_o,
  input  logic [31:0] mul_result_i
);

  logic [1:0]       elig, gnt, rls, cap;
  logic [1:0]       busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic             rr_last_q, rr_last_d;
  logic [Latency:0] vpipe_q, vpipe_d, tpipe_q, tpipe_d;
  logic [31:0]      mul_src1_q, mul_src1_d, mul_src2_q, mul_src2_d;
  logic [31:0]      res0_q, res0_d, res1_q, res1_d;

  // Grant is a function of req, busy and rr_last only; rsp_ready never reaches it.
  always_comb begin
    elig = {r1_req_i, r0_req_i} & ~busy_q;
    gnt  = 2'b00;
    if (rst_ni) begin
      unique case (elig)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    vpipe_d    = {vpipe_q[Latency-1:0], |gnt};
    tpipe_d    = {tpipe_q[Latency-1:0], gnt[1]};
    rr_last_d  = (|gnt) ? gnt[1] : rr_last_q;
    mul_src1_d = mul_src1_q;
    mul_src2_d = mul_src2_q;
    if (gnt[1]) begin
      mul_src1_d = r1_src1_i;
      mul_src2_d = r1_src2_i;
    end else if (gnt[0]) begin
      mul_src1_d = r0_src1_i;
      mul_src2_d = r0_src2_i;
    end
    rls         = rsp_valid_q & {r1_rsp_ready_i, r0_rsp_ready_i};
    cap         = {vpipe_q[Latency] & tpipe_q[Latency], vpipe_q[Latency] & ~tpipe_q[Latency]};
    rsp_valid_d = (rsp_valid_q & ~rls) | cap;
    busy_d      = (busy_q & ~rls) | gnt;
    res0_d      = cap[0] ? mul_result_i : res0_q;
    res1_d      = cap[1] ? mul_result_i : res1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vpipe_q     <= '0;
      tpipe_q     <= '0;
      rr_last_q   <= 1'b1;
      busy_q      <= '0;
      rsp_valid_q <= '0;
      mul_src1_q  <= '0;
      mul_src2_q  <= '0;
      res0_q      <= '0;
      res1_q      <= '0;
    end else begin
      vpipe_q     <= vpipe_d;
      tpipe_q     <= tpipe_d;
      rr_last_q   <= rr_last_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      mul_src1_q  <= mul_src1_d;
      mul_src2_q  <= mul_src2_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
    end
  end

  assign r0_gnt_o       = gnt[0];
  assign r1_gnt_o       = gnt[1];
  assign r0_rsp_valid_o = rsp_valid_q[0];
  assign r1_rsp_valid_o = rsp_valid_q[1];
  assign r0_result_o    = res0_q;
  assign r1_result_o    = res1_q;
  assign mul_src1_o     = mul_src1_q;
  assign mul_src2_o     = mul_src2_q;

endmodule

// File: tb/tb_bemicro_cv_nios_mul_arbiter.sv
// Directed and random checks of the two-requester multiply arbiter, with a behavioural
// multiply cell of matching latency.
module tb_bemicro_cv_nios_mul_arbiter;

  localparam int unsigned LATENCY = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic        r0_gnt, r1_gnt, r0_rsp_valid, r1_rsp_valid;
  logic [31:0] r0_result, r1_result;
  logic        r0_rdy = 1'b0, r1_rdy = 1'b0;
  logic [31:0] mul_src1, mul_src2, mul_result;
  logic [31:0] cell_q [LATENCY];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Multiply cell: LATENCY register stages from operands to result.
  always @(posedge clk) begin
    cell_q[0] <= mul_src1 * mul_src2;
    for (int k = 1; k < int'(LATENCY); k++) cell_q[k] <= cell_q[k-1];
  end
  assign mul_result = cell_q[LATENCY-1];

  bemicro_cv_nios_mul_arbiter #(.Latency(LATENCY)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .r0_req_i       (r0_req),
    .r0_src1_i      (r0_a),
    .r0_src2_i      (r0_b),
    .r0_gnt_o       (r0_gnt),
    .r0_rsp_valid_o (r0_rsp_valid),
    .r0_result_o    (r0_result),
    .r0_rsp_ready_i (r0_rdy),
    .r1_req_i       (r1_req),
    .r1_src1_i      (r1_a),
    .r1_src2_i      (r1_b),
    .r1_gnt_o       (r1_gnt),
    .r1_rsp_valid_o (r1_rsp_valid),
    .r1_result_o    (r1_result),
    .r1_rsp_ready_i (r1_rdy),
    .mul_src1_o     (mul_src1),
    .mul_src2_o     (mul_src2),
    .mul_result_i   (mul_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r0_req = 1'b0;
    r1_req = 1'b0;
    rst_n  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    r0_req = 1'b1;
    r1_req = 1'b1;
    tick();
    n_vec++;
    if ({r1_gnt, r0_gnt} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_gnt: got %b want 00", {r1_gnt, r0_gnt});
    end
    n_vec++;
    if ({r1_rsp_valid, r0_rsp_valid, r0_result, r1_result, mul_src1, mul_src2} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b r0=%h r1=%h s1=%h s2=%h want all 0",
               {r1_rsp_valid, r0_rsp_valid}, r0_result, r1_result, mul_src1, mul_src2);
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    rst_n  = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    r0_rdy = 1'b1;
    r1_rdy = 1'b1;
    r0_req = 1'b1;
    r0_a   = 32'h0001_0003;
    r0_b   = 32'h0000_0005;
    #1;
    n_vec++;
    if ({r1_gnt, r0_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL single_gnt: got %b want 01", {r1_gnt, r0_gnt});
    end
    tick();
    r0_req = 1'b0;
    n_vec++;
    if (mul_src1 !== 32'h0001_0003 || mul_src2 !== 32'h0000_0005) begin
      n_err++;
      $display("FAIL single_operands: got %h*%h want 00010003*00000005", mul_src1, mul_src2);
    end
    for (int c = 1; c <= 4; c++) begin
      n_vec++;
      if (r0_rsp_valid !== (c == 3)) begin
        n_err++;
        $display("FAIL single_valid_T%0d: got %b want %b", c, r0_rsp_valid, (c == 3));
      end
      if (c == 3) begin
        n_vec++;
        if (r0_result !== 32'h0005_000F) begin
          n_err++;
          $display("FAIL single_result: got %h want 0005000f", r0_result);
        end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    do_reset();
    r0_rdy = 1'b1;
    r1_rdy = 1'b1;
    r0_req = 1'b1; r0_a = 32'd2; r0_b = 32'd3;
    r1_req = 1'b1; r1_a = 32'd7; r1_b = 32'd9;
    #1;
    n_vec++;
    if ({r1_gnt, r0_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL contention_first: got %b want 01", {r1_gnt, r0_gnt});
    end
    tick();
    r0_req = 1'b0;
    #1;
    n_vec++;
    if ({r1_gnt, r0_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL contention_second: got %b want 10", {r1_gnt, r0_gnt});
    end
    tick();
    r1_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      n_vec++;
      if ({r1_rsp_valid, r0_rsp_valid} !== ((c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00)) begin
        n_err++;
        $display("FAIL contention_valid_T%0d: got %b", c, {r1_rsp_valid, r0_rsp_valid});
      end
      if (c == 3) begin
        n_vec++;
        if (r0_result !== 32'd6) begin
          n_err++;
          $display("FAIL contention_r0_result: got %0d want 6", r0_result);
        end
      end
      if (c == 4) begin
        n_vec++;
        if (r1_result !== 32'd63) begin
          n_err++;
          $display("FAIL contention_r1_result: got %0d want 63", r1_result);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_gnt;
    do_reset();
    r0_rdy = 1'b1;
    r0_req = 1'b1; r0_a = 32'd3; r0_b = 32'd11;
    r1_req = 1'b1; r1_a = 32'd4; r1_b = 32'd5;
    for (int c = 0; c <= 15; c++) begin
      r1_rdy = (c >= 14);
      #1;
      exp_gnt = {(c == 1 || c == 15), (c % 4 == 0)};
      n_vec++;
      if ({r1_gnt, r0_gnt} !== exp_gnt) begin
        n_err++;
        $display("FAIL bp_gnt_c%0d: got %b want %b", c, {r1_gnt, r0_gnt}, exp_gnt);
      end
      n_vec++;
      if (r1_rsp_valid !== (c >= 4 && c <= 14)) begin
        n_err++;
        $display("FAIL bp_r1_valid_c%0d: got %b want %b", c, r1_rsp_valid, (c >= 4 && c <= 14));
      end
      if (c >= 4 && c <= 14) begin
        n_vec++;
        if (r1_result !== 32'd20) begin
          n_err++;
          $display("FAIL bp_r1_hold_c%0d: got %0d want 20", c, r1_result);
        end
      end
      if (c % 4 == 3) begin
        n_vec++;
        if (r0_rsp_valid !== 1'b1 || r0_result !== 32'd33) begin
          n_err++;
          $display("FAIL bp_r0_rsp_c%0d: got v=%b %0d want v=1 33", c, r0_rsp_valid, r0_result);
        end
      end
      tick();
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_wrap();
    logic [31:0] va [2];
    logic [31:0] vexp [2];
    int          waited;
    va[0] = 32'hFFFF_FFFF; vexp[0] = 32'h0000_0001;
    va[1] = 32'h0001_0000; vexp[1] = 32'h0000_0000;
    r0_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r0_req = 1'b1;
      r0_a   = va[i];
      r0_b   = va[i];
      tick();
      r0_req = 1'b0;
      waited = 0;
      while (!r0_rsp_valid && waited < 10) begin
        tick();
        waited++;
      end
      n_vec++;
      if (!r0_rsp_valid) begin
        n_err++;
        $display("FAIL wrap_timeout_%0d: got no rsp_valid want rsp_valid within 10 cycles", i);
      end else if (r0_result !== vexp[i]) begin
        n_err++;
        $display("FAIL wrap_result_%0d: got %h want %h", i, r0_result, vexp[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    r0_rdy = 1'b1;
    r1_rdy = 1'b1;
    r0_req = 1'b1; r0_a = 32'h0000_1234; r0_b = 32'h0000_0010;
    r1_req = 1'b0;
    #1;
    n_vec++;
    if (r0_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midflight_gnt: got %b want 1", r0_gnt);
    end
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({r1_gnt, r0_gnt, r1_rsp_valid, r0_rsp_valid} !== 4'b0000 ||
        {r0_result, r1_result, mul_src1, mul_src2} !== '0) begin
      n_err++;
      $display("FAIL midflight_clear: got g=%b v=%b r0=%h r1=%h s1=%h s2=%h want all 0",
               {r1_gnt, r0_gnt}, {r1_rsp_valid, r0_rsp_valid}, r0_result, r1_result,
               mul_src1, mul_src2);
    end
    tick();
    tick();
    rst_n  = 1'b1;
    r0_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if ({r1_rsp_valid, r0_rsp_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL midflight_no_rsp_%0d: got %b want 00", c, {r1_rsp_valid, r0_rsp_valid});
      end
    end
    r0_req = 1'b1; r0_a = 32'd1; r0_b = 32'd1;
    r1_req = 1'b1; r1_a = 32'd1; r1_b = 32'd1;
    #1;
    n_vec++;
    if ({r1_gnt, r0_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL midflight_rr: got %b want 01", {r1_gnt, r0_gnt});
    end
    tick();
    r0_req = 1'b0;
    tick();
    r1_req = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_soak();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] expv;
    logic        g0, g1;
    int          ncyc;
    ncyc = 3000;
    g0 = 1'b0;
    g1 = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (cyc >= ncyc - 20) begin
        r0_req = 1'b0; r1_req = 1'b0; r0_rdy = 1'b1; r1_rdy = 1'b1;
      end else begin
        if (!r0_req || g0) begin
          r0_req = 1'($urandom_range(0, 1));
          r0_a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          r0_b   = $urandom;
        end
        if (!r1_req || g1) begin
          r1_req = 1'($urandom_range(0, 1));
          r1_a   = $urandom;
          r1_b   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        r0_rdy = ($urandom_range(0, 3) != 0);
        r1_rdy = ($urandom_range(0, 2) != 0);
      end
      #1;
      g0 = r0_gnt;
      g1 = r1_gnt;
      if (g0 && g1) begin
        n_vec++;
        n_err++;
        $display("FAIL soak_double_gnt_%0d: got 11 want at most one grant", cyc);
      end
      if (g0) q0.push_back(r0_a * r0_b);
      if (g1) q1.push_back(r1_a * r1_b);
      if (r0_rsp_valid && r0_rdy) begin
        n_vec++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL soak_r0_extra_%0d: got response %h want none outstanding", cyc, r0_result);
        end else begin
          expv = q0.pop_front();
          if (r0_result !== expv) begin
            n_err++;
            $display("FAIL soak_r0_%0d: got %h want %h", cyc, r0_result, expv);
          end
        end
      end
      if (r1_rsp_valid && r1_rdy) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL soak_r1_extra_%0d: got response %h want none outstanding", cyc, r1_result);
        end else begin
          expv = q1.pop_front();
          if (r1_result !== expv) begin
            n_err++;
            $display("FAIL soak_r1_%0d: got %h want %h", cyc, r1_result, expv);
          end
        end
      end
      tick();
    end
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL soak_drain: got %0d/%0d outstanding want 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
